fft_frame_buf: RTL and testbench



---
 rtl/fft_frame_buf.sv | 184 ++++++++++++++++++
 tb/tb_fft_frame_buf.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buf.sv
// -----------------------------------------------------------------------------
// fft_frame_buf
//
// Collects complex samples (one per input handshake) into N_POINTS-sample
// frames and presents each finished frame as a single wide bus to the next
// FFT stage. Two banks are used ping-pong style: one fills while the other is
// presented. Valid/ready flow control is provided on both sides. Optionally,
// samples are placed in bit-reversed slot order.
//
// Parameters
//   NUMBER_BITS : width of each real / imaginary part
//   N_POINTS    : frame length (power of two, >= 2)
//   BIT_REV     : 0 -> sample k to slot k, 1 -> sample k to slot bitrev(k)
//
// Ports
//   clk_10    : clock, rising edge
//   rst_n     : asynchronous active-low reset (clears banks and control)
//   flush     : synchronous abort of all frames (bank contents kept)
//   in_valid  : in_data carries a sample
//   in_ready  : a sample can be accepted this cycle
//   in_data   : {real, imag} sample
//   out_valid : out_frame holds a complete frame
//   out_ready : consumer takes the frame this cycle
//   out_frame : slot s at bits [(s+1)*2*NUMBER_BITS-1 : s*2*NUMBER_BITS]
//   fill_cnt  : samples already accepted into the frame being filled
// -----------------------------------------------------------------------------
module fft_frame_buf #(
  parameter int NUMBER_BITS = 22,
  parameter int N_POINTS    = 32,
  parameter int BIT_REV     = 0
) (
  input  logic                                clk_10,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [2*NUMBER_BITS-1:0]            in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_POINTS*2*NUMBER_BITS-1:0]   out_frame,
  output logic [$clog2(N_POINTS)-1:0]         fill_cnt
);

  localparam int SW = 2 * NUMBER_BITS;
  localparam int AW = $clog2(N_POINTS);

  localparam logic [AW-1:0] CNT_ZERO = AW'(0);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_LAST = AW'(N_POINTS - 1);

  // Reverse the bit order of a slot index.
  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = v;
    for (int i = 0; i < AW; i++) begin
      r[i] = v[AW-1-i];
    end
    return r;
  endfunction

  // Storage and control state.
  logic [SW-1:0] bank_r [2][N_POINTS];
  logic          wr_sel_r;
  logic          rd_sel_r;
  logic [1:0]    full_r;
  logic [AW-1:0] wr_cnt_r;

  // Next-state and handshake signals.
  logic          wr_sel_nxt_s;
  logic          rd_sel_nxt_s;
  logic [1:0]    full_nxt_s;
  logic [AW-1:0] wr_cnt_nxt_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          accept_s;
  logic          take_s;
  logic          last_s;
  logic          bank_we_s;
  logic [AW-1:0] slot_s;
  logic [N_POINTS*SW-1:0] out_frame_s;

  // Handshake qualifiers. Flush suppresses both sides so neither the bank
  // write nor any counter movement happens on a flush edge.
  always_comb begin
    in_ready_s  = ~full_r[wr_sel_r];
    out_valid_s = full_r[rd_sel_r];
    accept_s    = in_valid & in_ready_s;
    take_s      = out_valid_s & out_ready;
    last_s      = (wr_cnt_r == CNT_LAST);
    bank_we_s   = accept_s & ~flush;
  end

  // Slot selection: natural or bit-reversed order.
  always_comb begin
    slot_s = wr_cnt_r;
    if (BIT_REV != 0) begin
      slot_s = bit_rev(wr_cnt_r);
    end else begin
      slot_s = wr_cnt_r;
    end
  end

  // Control next-state. Completion only ever sets the full bit of the bank
  // being written (which is empty) and a take only clears the full bit of the
  // bank being read (which is full), so both may apply on the same edge
  // without conflicting.
  always_comb begin
    wr_cnt_nxt_s = wr_cnt_r;
    wr_sel_nxt_s = wr_sel_r;
    rd_sel_nxt_s = rd_sel_r;
    full_nxt_s   = full_r;
    if (flush) begin
      wr_cnt_nxt_s = CNT_ZERO;
      wr_sel_nxt_s = 1'b0;
      rd_sel_nxt_s = 1'b0;
      full_nxt_s   = 2'b00;
    end else begin
      if (accept_s) begin
        if (last_s) begin
          wr_cnt_nxt_s         = CNT_ZERO;
          wr_sel_nxt_s         = ~wr_sel_r;
          full_nxt_s[wr_sel_r] = 1'b1;
        end else begin
          wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
        end
      end else begin
        wr_cnt_nxt_s = wr_cnt_r;
      end
      if (take_s) begin
        rd_sel_nxt_s         = ~rd_sel_r;
        full_nxt_s[rd_sel_r] = 1'b0;
      end else begin
        rd_sel_nxt_s = rd_sel_r;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r <= CNT_ZERO;
      wr_sel_r <= 1'b0;
      rd_sel_r <= 1'b0;
      full_r   <= 2'b00;
    end else begin
      wr_cnt_r <= wr_cnt_nxt_s;
      wr_sel_r <= wr_sel_nxt_s;
      rd_sel_r <= rd_sel_nxt_s;
      full_r   <= full_nxt_s;
    end
  end

  // Sample banks. The bank being presented is never written because writes
  // require its full bit to be clear, which keeps out_frame stable under
  // backpressure.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N_POINTS; s++) begin
          bank_r[b][s] <= {SW{1'b0}};
        end
      end
    end else if (bank_we_s) begin
      bank_r[wr_sel_r][slot_s] <= in_data;
    end
  end

  // Pack the presented bank onto the wide output bus.
  always_comb begin
    out_frame_s = {(N_POINTS*SW){1'b0}};
    for (int s = 0; s < N_POINTS; s++) begin
      out_frame_s[s*SW +: SW] = bank_r[rd_sel_r][s];
    end
  end

  // Output drive.
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = out_valid_s;
    out_frame = out_frame_s;
    fill_cnt  = wr_cnt_r;
  end

endmodule

// File: tb/tb_fft_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_buf
//
// Directed bench for fft_frame_buf. The main instance uses default parameters
// and is checked every cycle against a small frame scoreboard: completed
// frames are queued as the bench drives their last sample and compared with
// out_frame while they are presented. A second instance (8 points,
// bit-reversed) checks slot placement against a fixed table.
// -----------------------------------------------------------------------------
module tb_fft_frame_buf;

  localparam int NB  = 22;
  localparam int SW  = 2 * NB;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int FW  = N * SW;
  localparam int N8  = 8;
  localparam int AW8 = 3;
  localparam int FW8 = N8 * SW;

  logic           clk_10;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [FW-1:0]  out_frame;
  logic [AW-1:0]  fill_cnt;

  logic           flush8;
  logic           in_valid8;
  logic           in_ready8;
  logic [SW-1:0]  in_data8;
  logic           out_valid8;
  logic           out_ready8;
  logic [FW8-1:0] out_frame8;
  logic [AW8-1:0] fill_cnt8;

  int checks   = 0;
  int failures = 0;
  int kk       = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur_frame;
  int            cur_cnt;

  fft_frame_buf #(.NUMBER_BITS(NB), .N_POINTS(N), .BIT_REV(0)) dut (
    .clk_10    (clk_10),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frame (out_frame),
    .fill_cnt  (fill_cnt)
  );

  fft_frame_buf #(.NUMBER_BITS(NB), .N_POINTS(N8), .BIT_REV(1)) dut8 (
    .clk_10    (clk_10),
    .rst_n     (rst_n),
    .flush     (flush8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_frame (out_frame8),
    .fill_cnt  (fill_cnt8)
  );

  initial begin
    clk_10 = 1'b0;
    forever #5 clk_10 = ~clk_10;
  end

  function automatic logic [SW-1:0] sample(input int k);
    logic [NB-1:0] re;
    logic [NB-1:0] im;
    re = NB'(k);
    im = NB'(-k);
    return {re, im};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    int bad;
    bad = 0;
    for (int s = N - 1; s >= 0; s--) begin
      if (obs[s*SW +: SW] !== exp[s*SW +: SW]) bad = s;
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, bad,
             obs[bad*SW +: SW], exp[bad*SW +: SW]);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    cur_cnt   = 0;
    cur_frame = '0;
  endtask

  // One clock cycle: check outputs against the scoreboard, predict the
  // handshakes of the coming edge, update the model, then step past the edge.
  task automatic cyc(output bit acc);
    bit exp_rdy;
    bit exp_vld;
    bit tk;
    exp_rdy = (exp_q.size() < 2);
    exp_vld = (exp_q.size() > 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
    chk("fill_cnt", 64'(fill_cnt), 64'(cur_cnt));
    if (exp_vld) chk_frame("out_frame", out_frame, exp_q[0]);
    acc = !flush && in_valid && exp_rdy;
    tk  = !flush && exp_vld && out_ready;
    if (flush) begin
      reset_model();
    end else begin
      if (tk) void'(exp_q.pop_front());
      if (acc) begin
        cur_frame[cur_cnt*SW +: SW] = in_data;
        if (cur_cnt == N - 1) begin
          exp_q.push_back(cur_frame);
          cur_cnt = 0;
        end else begin
          cur_cnt++;
        end
      end
    end
    @(posedge clk_10);
    #1;
  endtask

  task automatic stream(input int n);
    int got;
    int spent;
    bit acc;
    got   = 0;
    spent = 0;
    while (got < n && spent < n + 200) begin
      in_valid = 1'b1;
      in_data  = sample(kk);
      cyc(acc);
      if (acc) begin
        kk++;
        got++;
      end
      spent++;
    end
    in_valid = 1'b0;
    chk("stream_done", 64'(got), 64'(n));
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc(acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_fill_cnt"}, 64'(fill_cnt), 64'd0);
    chk_frame({tag, "_out_frame"}, out_frame, {FW{1'b0}});
    chk({tag, "_out_valid8"}, {63'd0, out_valid8}, 64'd0);
  endtask

  initial begin
    int tbl[N8];
    bit acc;
    tbl = '{0, 4, 2, 6, 1, 5, 3, 7};
    rst_n      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush8     = 1'b0;
    in_valid8  = 1'b0;
    in_data8   = '0;
    out_ready8 = 1'b0;
    reset_model();

    // 1. Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk_10);
    #1;
    rst_n = 1'b1;

    // 2. Natural order, consumer always ready.
    out_ready = 1'b1;
    kk = 0;
    stream(32);
    idle(3);

    // 3. Bit-reversed 8-point instance.
    for (int k = 0; k < N8; k++) begin
      in_valid8 = 1'b1;
      in_data8  = {NB'(k), NB'(k)};
      chk("bitrev_in_ready", {63'd0, in_ready8}, 64'd1);
      cyc(acc);
    end
    in_valid8 = 1'b0;
    chk("bitrev_out_valid", {63'd0, out_valid8}, 64'd1);
    chk("bitrev_fill_cnt", 64'(fill_cnt8), 64'd0);
    for (int s = 0; s < N8; s++) begin
      chk("bitrev_slot", 64'(out_frame8[s*SW +: SW]), 64'({NB'(tbl[s]), NB'(tbl[s])}));
    end

    // 4. Backpressure: fill both banks, stall, then drain.
    out_ready = 1'b0;
    kk = 100;
    stream(64);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = sample(kk);
      cyc(acc);
      if (acc) kk++;
    end
    out_ready = 1'b1;
    stream(32);
    idle(4);

    // 5. Flush mid-frame, then a clean frame.
    kk = 500;
    stream(10);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = sample(kk);
    cyc(acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    kk = 0;
    stream(32);
    idle(3);

    // 6. Reset mid-operation with a frame presented and a half-filled bank.
    out_ready = 1'b0;
    kk = 700;
    stream(48);
    chk("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_reset_fill_cnt", 64'(fill_cnt), 64'd16);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_model();
    @(posedge clk_10);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    kk = 900;
    stream(32);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
